// File: rtl/lut_cfg_writer.sv
// lut_cfg_writer: assembles a byte stream into NUM_FRAGS 16-bit LUT truth
// tables. Each word arrives low byte first, then high byte; the word is
// written into slot frag_idx during a one-cycle COMMIT state.
// Optional feature: define LUT_CFG_PARITY_EN to require a check byte after
// each word (bit0 = XOR of the 16 word bits); a failed check sets the sticky
// err flag and the word is retried from its low byte.
// IDX_W must be wide enough to hold the value NUM_FRAGS (frag_idx reaches it
// in DONE).
module lut_cfg_writer #(
  parameter int NUM_FRAGS = 4,
  parameter int IDX_W     = 6
) (
  input  logic                    QCK,
  input  logic                    QRT,
  input  logic                    start,
  input  logic                    cfg_valid,
  input  logic [7:0]              cfg_byte,
  output logic                    cfg_ready,
  output logic [NUM_FRAGS*16-1:0] frag_cfg,
  output logic [IDX_W-1:0]        frag_idx,
  output logic                    done,
  output logic                    err
);

`ifdef LUT_CFG_PARITY_EN
  typedef enum logic [2:0] {IDLE, LO, HI, CHK, COMMIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LO, HI, COMMIT, DONE} state_t;
`endif

  // Slot count widened by one bit so the "all slots written" compare is exact.
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_FRAGS);

  state_t                  state_q;
  logic [7:0]              lo_q;
  logic [7:0]              hi_q;
  logic [NUM_FRAGS*16-1:0] frag_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    done_q;
  logic                    ready_q;
`ifdef LUT_CFG_PARITY_EN
  logic                    err_q;
  logic                    parity_ok_d;
`endif

  logic                    accept_d;
  logic [IDX_W:0]          idx_inc_d;
  logic [15:0]             word_d;

  // Handshake qualifier, assembled word and incremented slot index.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, here
    // unconditionally, so no latch can be inferred.
    accept_d  = cfg_valid & ready_q;
    idx_inc_d = {1'b0, idx_q} + (IDX_W+1)'(1);
    word_d    = {hi_q, lo_q};
`ifdef LUT_CFG_PARITY_EN
    parity_ok_d = (cfg_byte[0] == ^word_d);
`endif
  end

  // Load sequencer: reset beats start, start beats any byte handshake.
  always_ff @(posedge QCK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (QRT) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      // NOTE: the slot storage is reset on purpose: downstream LUTs must see a
      // defined all-zero function until a word is loaded.
      frag_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else if (start) begin
      // Abort any word in progress; slot contents are kept.
      state_q <= LO;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef LUT_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Wait for start; bytes are not accepted (ready_q is low).
        end
        LO: begin
          if (accept_d) begin
            lo_q    <= cfg_byte;
            state_q <= HI;
          end
        end
        HI: begin
          if (accept_d) begin
            hi_q    <= cfg_byte;
`ifdef LUT_CFG_PARITY_EN
            state_q <= CHK;
`else
            state_q <= COMMIT;
            ready_q <= 1'b0;
`endif
          end
        end
`ifdef LUT_CFG_PARITY_EN
        CHK: begin
          if (accept_d) begin
            if (parity_ok_d) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end else begin
              // Bad check byte: flag it and retry the same slot.
              err_q   <= 1'b1;
              state_q <= LO;
            end
          end
        end
`endif
        COMMIT: begin
          for (int i = 0; i < NUM_FRAGS; i++) begin
            if (idx_q == IDX_W'(i)) frag_q[16*i +: 16] <= word_d;
          end
          idx_q <= idx_inc_d[IDX_W-1:0];
          if (idx_inc_d == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LO;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign frag_cfg  = frag_q;
  assign frag_idx  = idx_q;
  assign done      = done_q;
`ifdef LUT_CFG_PARITY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Testbench for lut_cfg_writer: a 4-slot instance and a 1-slot instance share
// one input stream; a slot-array model predicts both. Works with or without
// LUT_CFG_PARITY_EN defined.
module tb_lut_cfg_writer;
  localparam int NF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cfg_valid;
  logic [7:0]    cfg_byte;
  logic          cfg_ready, done, err;
  logic [NF*16-1:0] frag_cfg;
  logic [5:0]    frag_idx;
  logic          cfg_ready1, done1, err1;
  logic [15:0]   frag_cfg1;
  logic [5:0]    frag_idx1;

  lut_cfg_writer #(.NUM_FRAGS(NF), .IDX_W(6)) u_dut (
    .QCK(clk), .QRT(rst), .start(start), .cfg_valid(cfg_valid), .cfg_byte(cfg_byte),
    .cfg_ready(cfg_ready), .frag_cfg(frag_cfg), .frag_idx(frag_idx), .done(done), .err(err)
  );

  lut_cfg_writer #(.NUM_FRAGS(1), .IDX_W(6)) u_dut1 (
    .QCK(clk), .QRT(rst), .start(start), .cfg_valid(cfg_valid), .cfg_byte(cfg_byte),
    .cfg_ready(cfg_ready1), .frag_cfg(frag_cfg1), .frag_idx(frag_idx1), .done(done1), .err(err1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: slot contents plus progress flags for each instance.
  logic [15:0] m_frag [NF];
  int          m_idx;
  bit          m_done, m_err;
  logic [15:0] m1_word;
  int          m1_idx;
  bit          m1_done, m1_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF*16-1:0] model_flat();
    logic [NF*16-1:0] r;
    for (int i = 0; i < NF; i++) r[16*i +: 16] = m_frag[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_frag[i] = 16'h0;
    m_idx = 0; m_done = 0; m_err = 0;
    m1_word = 16'h0; m1_idx = 0; m1_done = 0; m1_err = 0;
  endtask

  task automatic model_start();
    m_idx = 0; m_done = 0; m_err = 0;
    m1_idx = 0; m1_done = 0; m1_err = 0;
  endtask

  task automatic model_commit(input logic [15:0] w);
    m_frag[m_idx] = w;
    m_idx++;
    m_done = (m_idx == NF);
    if (!m1_done) begin
      m1_word = w; m1_idx = 1; m1_done = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".frag"},  frag_cfg,  model_flat());
    check({tag, ".idx"},   frag_idx,  64'(m_idx));
    check({tag, ".done"},  done,      64'(m_done));
    check({tag, ".err"},   err,       64'(m_err));
    check({tag, ".frag1"}, frag_cfg1, m1_word);
    check({tag, ".idx1"},  frag_idx1, 64'(m1_idx));
    check({tag, ".done1"}, done1,     64'(m1_done));
    check({tag, ".err1"},  err1,      64'(m1_err));
  endtask

  task automatic pulse_start();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  // Offer one byte; returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      cfg_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    cfg_valid = 1'b1;
    cfg_byte  = b;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (cfg_ready !== 1'b1) check("ready_timeout", cfg_ready, 1);
    tick();
  endtask

  // Full word load including the check byte when the feature is built in.
  task automatic load_word(input logic [15:0] w, input bit gaps);
    send_byte(w[7:0], gaps);
    send_byte(w[15:8], gaps);
`ifdef LUT_CFG_PARITY_EN
    send_byte({7'($urandom), ^w}, gaps);
`endif
    if (gaps && $urandom_range(0, 1) == 0) cfg_valid = 1'b0;
    check("commit_ready_low", cfg_ready, 0);
    check("commit_not_early", frag_cfg, model_flat());
    model_commit(w);
    tick();
    check_all("word");
    check("post_commit_ready", cfg_ready, m_done ? 64'd0 : 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with start and cfg_valid also high: reset must win.
    rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_byte = 8'hA5;
    model_reset();
    repeat (2) tick();
    check("reset_ready", cfg_ready, 0);
    check_all("reset");
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("idle_ready", cfg_ready, 0);
    check_all("idle");

    // Directed words with cfg_valid held high throughout.
    pulse_start();
    check("start_ready", cfg_ready, 1);
    check_all("start");
    load_word(16'h8000, 0);
    load_word(16'hFFFE, 0);
    load_word(16'h0001, 0);
    load_word(16'hAAAA, 0);
    check("directed_frag", frag_cfg, 64'hAAAA_0001_FFFE_8000);
    check("directed_done", done, 1);
    check("one_slot_frag", frag_cfg1, 64'h8000);

    // Bytes offered while DONE are ignored.
    cfg_valid = 1'b1; cfg_byte = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_ready", cfg_ready, 0);
    end
    check_all("done_hold");

    // Single-slot instance: bytes 0x96, 0x69 complete it.
    pulse_start();
    load_word(16'h6996, 0);
    check("one_slot_6996", frag_cfg1, 64'h6996);
    check("one_slot_done", done1, 1);
    check("one_slot_idx", frag_idx1, 1);
    for (int k = 0; k < 3; k++) load_word(16'($urandom), 1);
    cfg_valid = 1'b0;

    // Randomized rounds with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      for (int k = 0; k < NF; k++) load_word(16'($urandom), 1);
      cfg_valid = 1'b0;
      tick();
      check_all("rand_round");
    end

    // start in the same cycle as an accepted high byte aborts the word.
    pulse_start();
    send_byte(8'h55, 0);
    cfg_byte = 8'h77; cfg_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    model_start();
    check("abort_ready", cfg_ready, 1);
    check_all("abort");
    load_word(16'h1234, 0);
    cfg_valid = 1'b0;
    check("abort_slot0", frag_cfg[15:0], 64'h1234);

`ifdef LUT_CFG_PARITY_EN
    // Wrong check byte: err set, no write, word retried.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    cfg_valid = 1'b0;
    m_err = 1;
    if (!m1_done) m1_err = 1;
    check("chk_bad_ready", cfg_ready, 1);
    check_all("chk_bad");
    load_word(16'h0001, 0);
    cfg_valid = 1'b0;
    check("chk_retry_slot0", frag_cfg[15:0], 64'h0001);
    check("chk_err_sticky", err, 1);
`endif

    // Reset mid-word after three committed words.
    pulse_start();
    for (int k = 0; k < 3; k++) load_word(16'($urandom), 1);
    send_byte(8'($urandom), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midreset_ready", cfg_ready, 0);
    check_all("midreset");
    cfg_valid = 1'b1;
    repeat (5) tick();
    check("midreset_idle_ready", cfg_ready, 0);
    check_all("midreset_idle");

    // Recovery after reset.
    pulse_start();
    load_word(16'hC3A5, 1);
    cfg_valid = 1'b0;
    tick();
    check_all("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lut_cfg_writer.md
LUT_CFG_WRITER -- requirements
Module: lut_cfg_writer

Interface
REQ-001 Parameter NUM_FRAGS, default 4, SHALL set the number of 16-bit LUT fragment configuration words driven (range 1..64).
REQ-002 Parameter IDX_W, default 6, SHALL set the width of frag_idx.
REQ-003 QCK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 QRT  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL be a single-cycle pulse that begins a new load sequence.
REQ-006 cfg_valid  input  1  SHALL qualify cfg_byte.
REQ-007 cfg_byte  input  8  SHALL carry configuration stream bytes.
REQ-008 cfg_ready  output  1  SHALL indicate the block accepts cfg_byte this cycle.
REQ-009 frag_cfg  output  NUM_FRAGS*16  SHALL be registered LUT truth tables; word i is bits [16i+15:16i], bit n is the LUT output for input index n (I0 = LSB).
REQ-010 frag_idx  output  IDX_W  SHALL give the index of the next word to be written.
REQ-011 done  output  1  SHALL flag that all NUM_FRAGS words are written.
REQ-012 err  output  1  SHALL be the sticky check-error flag (Configuration section).

Function
REQ-013 A byte SHALL be accepted only on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_valid=1 with cfg_ready=0 SHALL have no effect.
REQ-014 FSM states SHALL be IDLE, LO, HI, CHK (macro only), COMMIT, DONE.
REQ-015 IDLE: cfg_ready=0; start -> LO with frag_idx=0, done=0, err=0.
REQ-016 LO: cfg_ready=1; an accepted byte forms word bits [7:0] -> HI.
REQ-017 HI: cfg_ready=1; an accepted byte forms word bits [15:8] -> COMMIT (or CHK with the macro).
REQ-018 COMMIT: cfg_ready=0 for exactly one cycle; on its closing edge the assembled word SHALL be written to slot frag_idx and frag_idx SHALL increment.
REQ-019 A word SHALL become visible on frag_cfg one clock after the edge that accepts its final byte; other slots SHALL be unchanged.
REQ-020 After COMMIT: if the incremented frag_idx equals NUM_FRAGS -> DONE, else -> LO.
REQ-021 DONE: done=1, cfg_ready=0; frag_idx SHALL hold NUM_FRAGS; start -> LO as in REQ-015.
REQ-022 start in LO/HI/CHK/COMMIT SHALL abort the word in progress (no write), clear frag_idx, done and err, and enter LO.
REQ-023 start SHALL take priority over a byte handshake in the same cycle; that byte SHALL be discarded.
REQ-024 start SHALL NOT clear frag_cfg; slots SHALL keep their contents until overwritten.

Reset
REQ-025 With QRT=1 at a rising edge: state=IDLE, frag_cfg=0, frag_idx=0, done=0, err=0, cfg_ready=0; a partial word SHALL be discarded.
REQ-026 QRT SHALL take priority over start and cfg_valid.

Configuration
REQ-027 Macro LUT_CFG_PARITY_EN SHALL enable a per-word check byte.
REQ-028 With the macro: after HI -> CHK (cfg_ready=1); the accepted byte bit0 SHALL equal the XOR of all 16 word bits; bits [7:1] are ignored.
REQ-029 With the macro: on match -> COMMIT; on mismatch err<=1, no write, frag_idx unchanged, -> LO (word retried).
REQ-030 Without the macro: state CHK is absent, HI -> COMMIT, err SHALL be tied to 0, and the stream is 2 bytes per word.

Verification
REQ-031 Reset, then start, then bytes 0x96,0x69 (macro off), NUM_FRAGS=1 -> frag_cfg=0x6996 one clock after the 2nd accept; done=1; frag_idx=1.
REQ-032 NUM_FRAGS=4, words 0x8000,0xFFFE,0x0001,0xAAAA with cfg_valid held high -> each COMMIT inserts one cycle with cfg_ready=0; final frag_cfg=0xAAAA_0001_FFFE_8000; done=1.
REQ-033 Macro on: 0x01,0x00 + check 0x00 -> err=1, frag_idx=0, slot 0 unchanged; then 0x01,0x00,0x01 -> slot 0=0x0001; err remains 1.
REQ-034 start asserted in the same cycle as an accepted HI byte -> no write, frag_idx=0, state LO; the following bytes 0x34,0x12 -> slot 0=0x1234.
REQ-035 QRT asserted mid-word after 3 committed words -> all outputs 0 on the next cycle; cfg_ready stays 0 until start.
REQ-036 In DONE, cfg_valid=1 for 10 cycles -> cfg_ready=0, frag_cfg unchanged, done=1.
